// File: rtl/gpio_arbiter_pkg.sv
// Shared types and constants for the two-requester GPIO arbiter.
package gpio_arbiter_pkg;

  localparam int unsigned DataWidth = 32;

  // Transaction sequencer state, 2-bit encoded.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } state_e;

  // GPIO register map: a[1]=0 selects an input port, a[1]=1 an output port.
  localparam logic [1:0] IN1  = 2'b00;
  localparam logic [1:0] IN2  = 2'b01;
  localparam logic [1:0] OUT1 = 2'b10;
  localparam logic [1:0] OUT2 = 2'b11;

  // Only the output ports accept writes.
  function automatic logic is_out_port(logic [1:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/gpio_arbiter_if.sv
// Requester and GPIO-side bus bundle for gpio_arbiter.
interface gpio_arbiter_if;
  import gpio_arbiter_pkg::*;

  // Requester 0
  logic                 m0_req;
  logic                 m0_we;
  logic [1:0]           m0_a;
  logic [DataWidth-1:0] m0_wd;
  logic                 m0_ack;
  logic                 m0_err;
  logic [DataWidth-1:0] m0_rd;

  // Requester 1
  logic                 m1_req;
  logic                 m1_we;
  logic [1:0]           m1_a;
  logic [DataWidth-1:0] m1_wd;
  logic                 m1_ack;
  logic                 m1_err;
  logic [DataWidth-1:0] m1_rd;

  // GPIO block side
  logic                 g_we;
  logic [1:0]           g_a;
  logic [DataWidth-1:0] g_wd;
  logic [DataWidth-1:0] g_rd;

  // Status
  logic                 busy;
  logic [1:0]           grant;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_a, m0_wd,
    output m0_ack, m0_err, m0_rd,
    input  m1_req, m1_we, m1_a, m1_wd,
    output m1_ack, m1_err, m1_rd,
    output g_we, g_a, g_wd,
    input  g_rd,
    output busy, grant
  );

  // Requesters plus GPIO block view.
  modport master (
    output m0_req, m0_we, m0_a, m0_wd,
    input  m0_ack, m0_err, m0_rd,
    output m1_req, m1_we, m1_a, m1_wd,
    input  m1_ack, m1_err, m1_rd,
    input  g_we, g_a, g_wd,
    output g_rd,
    input  busy, grant
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbitration decision: round-robin or fixed priority to requester 0.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,  // 1 when requester 1 was served last
  input  logic       fixed_i,
  output logic [1:0] gnt_o
);

  // One-hot grant; on a tie the requester not served last wins unless fixed.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (fixed_i || last_i) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/gpio_arbiter.sv
// Arbitrates two requesters onto a single GPIO register port.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESP; all outputs are registered.
module gpio_arbiter
  import gpio_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic           clk,
  input logic           rst,
  gpio_arbiter_if.slave bus
);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 we_q, we_d;
  logic [1:0]           g_a_q, g_a_d;
  logic [DataWidth-1:0] g_wd_q, g_wd_d;
  logic                 g_we_q, g_we_d;
  logic [1:0]           ack_q, ack_d;
  logic [1:0]           err_q, err_d;
  logic [DataWidth-1:0] m0_rd_q, m0_rd_d;
  logic [DataWidth-1:0] m1_rd_q, m1_rd_d;
  logic                 busy_q, busy_d;

  logic [1:0]           req;
  logic [1:0]           gnt;
  logic                 sel_we;
  logic [1:0]           sel_a;
  logic [DataWidth-1:0] sel_wd;

  assign req = {bus.m1_req, bus.m0_req};

  rr_arb2 u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .fixed_i (FIXED_PRIO != 0),
    .gnt_o   (gnt)
  );

  // Pick the winning requester's fields for latching on entry to ISSUE.
  always_comb begin
    sel_we = bus.m0_we;
    sel_a  = bus.m0_a;
    sel_wd = bus.m0_wd;
    if (gnt[1]) begin
      sel_we = bus.m1_we;
      sel_a  = bus.m1_a;
      sel_wd = bus.m1_wd;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    g_a_d   = g_a_q;
    g_wd_d  = g_wd_q;
    g_we_d  = 1'b0;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    m0_rd_d = m0_rd_q;
    m1_rd_d = m1_rd_q;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StIssue;
          grant_d = gnt;
          last_d  = gnt[1];
          we_d    = sel_we;
          g_a_d   = sel_a;
          g_wd_d  = sel_wd;
          // Writes to input ports never reach the GPIO block.
          g_we_d  = sel_we & is_out_port(sel_a);
          busy_d  = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        state_d = StResp;
        ack_d   = grant_q;
        err_d   = grant_q & {2{we_q & ~is_out_port(g_a_q)}};
        if (grant_q[1]) begin
          m1_rd_d = bus.g_rd;
        end else begin
          m0_rd_d = bus.g_rd;
        end
      end
      StResp: begin
        state_d = StIdle;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      g_a_q   <= 2'b00;
      g_wd_q  <= '0;
      g_we_q  <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      m0_rd_q <= '0;
      m1_rd_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      g_a_q   <= g_a_d;
      g_wd_q  <= g_wd_d;
      g_we_q  <= g_we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      m0_rd_q <= m0_rd_d;
      m1_rd_q <= m1_rd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.m0_ack = ack_q[0];
  assign bus.m1_ack = ack_q[1];
  assign bus.m0_err = err_q[0];
  assign bus.m1_err = err_q[1];
  assign bus.m0_rd  = m0_rd_q;
  assign bus.m1_rd  = m1_rd_q;
  assign bus.g_we   = g_we_q;
  assign bus.g_a    = g_a_q;
  assign bus.g_wd   = g_wd_q;
  assign bus.busy   = busy_q;
  assign bus.grant  = grant_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Bench for gpio_arbiter: one round-robin and one fixed-priority instance.
module tb_gpio_arbiter;
  import gpio_arbiter_pkg::*;

  localparam logic [31:0] In1Val = 32'hA5A5_0001;
  localparam logic [31:0] In2Val = 32'hCAFE_0002;

  typedef struct {
    int          who;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    int          who;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          gwe;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc = 0;

  gpio_arbiter_if bus0();
  gpio_arbiter_if bus1();

  gpio_arbiter #(.FIXED_PRIO(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gpio_arbiter #(.FIXED_PRIO(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // GPIO block models: constant inputs, writable outputs.
  logic [31:0] g0_out1 = '0;
  logic [31:0] g0_out2 = '0;

  function automatic logic [31:0] gpio_read(input logic [1:0] a, input logic [31:0] o1,
                                            input logic [31:0] o2);
    case (a)
      IN1:     return In1Val;
      IN2:     return In2Val;
      OUT1:    return o1;
      default: return o2;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus0.g_we && bus0.g_a == OUT1) g0_out1 <= bus0.g_wd;
    if (bus0.g_we && bus0.g_a == OUT2) g0_out2 <= bus0.g_wd;
  end

  assign bus0.g_rd = gpio_read(bus0.g_a, g0_out1, g0_out2);
  assign bus1.g_rd = gpio_read(bus1.g_a, 32'h1111_0000, 32'h2222_0000);

  int          n_vec;
  int          n_fail;
  exp_t        sb[$];
  logic [1:0]  ack_now;
  logic [31:0] rd_exp0 = '0;
  logic [31:0] rd_exp1 = '0;
  int          gwe_total = 0;
  int          gwe_last = 0;
  vec_t        vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score any response from dut0.
  task automatic tick();
    exp_t e;
    int   w;
    @(negedge clk);
    ack_now = {bus0.m1_ack, bus0.m0_ack};
    if (!rst) begin
      rd_exp0 = '0;
      rd_exp1 = '0;
    end else begin
      if (bus0.g_we) begin
        gwe_total++;
        gwe_last = cyc;
      end
      if (ack_now != 2'b00) begin
        if (ack_now == 2'b11 || sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL ack_unexpected: acks %b with %0d pending", ack_now, sb.size());
        end else begin
          e = sb.pop_front();
          w = bus0.m1_ack ? 1 : 0;
          chk("ack_who", w, e.who);
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_rd", w != 0 ? bus0.m1_rd : bus0.m0_rd, e.rd);
          chk("ack_err", w != 0 ? bus0.m1_err : bus0.m0_err, e.err);
          chk("ack_grant", bus0.grant, (e.who != 0) ? 2'b10 : 2'b01);
          chk("ack_busy", bus0.busy, 1);
          if (w != 0) rd_exp1 = e.rd;
          else        rd_exp0 = e.rd;
          chk("other_rd", w != 0 ? bus0.m0_rd : bus0.m1_rd, w != 0 ? rd_exp0 : rd_exp1);
          chk("other_err", w != 0 ? bus0.m0_err : bus0.m1_err, 0);
        end
      end
    end
  endtask

  task automatic drive(input int who, input logic req, input logic we, input logic [1:0] a,
                       input logic [31:0] wd);
    if (who == 0) begin
      bus0.m0_req = req; bus0.m0_we = we; bus0.m0_a = a; bus0.m0_wd = wd;
    end else begin
      bus0.m1_req = req; bus0.m1_we = we; bus0.m1_a = a; bus0.m1_wd = wd;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, bus0.busy, 0);
    chk({tag, "_grant"}, bus0.grant, 0);
    chk({tag, "_g_we"}, bus0.g_we, 0);
    chk({tag, "_g_a"}, bus0.g_a, 0);
    chk({tag, "_g_wd"}, bus0.g_wd, 0);
    chk({tag, "_acks"}, {bus0.m1_ack, bus0.m0_ack}, 0);
    chk({tag, "_errs"}, {bus0.m1_err, bus0.m0_err}, 0);
    chk({tag, "_m0_rd"}, bus0.m0_rd, 0);
    chk({tag, "_m1_rd"}, bus0.m1_rd, 0);
  endtask

  // One requester alone: ack three cycles after the sampling edge.
  task automatic do_single(input int who, input logic we, input logic [1:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_gwe);
    int got;
    int g0;
    int c0;
    tick();
    drive(who, 1'b1, we, a, wd);
    c0 = cyc;
    g0 = gwe_total;
    sb.push_back('{who, exp_rd, exp_err, c0 + 3});
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (ack_now[who] == 1'b1) got = 1;
    end
    drive(who, 1'b0, 1'b0, 2'b00, '0);
    chk("ack_seen", got, 1);
    chk("gwe_cycles", gwe_total - g0, exp_gwe);
    if (exp_gwe != 0) chk("gwe_when", gwe_last, c0 + 1);
  endtask

  // Both requesters read at the same edge; each drops req once acked.
  task automatic tie_rd(input int first);
    int got;
    int who;
    int second;
    second = 1 - first;
    tick();
    drive(0, 1'b1, 1'b0, OUT1, '0);
    drive(1, 1'b1, 1'b0, OUT2, '0);
    sb.push_back('{first, (first != 0) ? g0_out2 : g0_out1, 1'b0, cyc + 3});
    sb.push_back('{second, (second != 0) ? g0_out2 : g0_out1, 1'b0, cyc + 7});
    for (int k = 0; k < 2; k++) begin
      who = (k == 0) ? first : second;
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
        tick();
        if (ack_now[who] == 1'b1) got = 1;
      end
      drive(who, 1'b0, 1'b0, 2'b00, '0);
      chk("tie_ack_seen", got, 1);
    end
  endtask

  initial begin
    int got;
    int c0;
    int acks;
    int n0a;
    int n1a;
    int g1c;
    n_vec  = 0;
    n_fail = 0;
    rst    = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, '0);
    drive(1, 1'b0, 1'b0, 2'b00, '0);
    bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_a = 2'b00; bus1.m0_wd = '0;
    bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_a = 2'b00; bus1.m1_wd = '0;

    //               who we    a     wd             rd             err  gwe
    vecs[0] = '{0, 1'b1, OUT1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[1] = '{0, 1'b0, OUT1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0};
    vecs[2] = '{1, 1'b1, IN2,  32'h1234_5678, In2Val,        1'b1, 0};
    vecs[3] = '{1, 1'b0, IN1,  32'h0000_0000, In1Val,        1'b0, 0};
    vecs[4] = '{1, 1'b1, OUT2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1};
    vecs[5] = '{0, 1'b0, OUT2, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 0};
    vecs[6] = '{0, 1'b1, IN1,  32'hFFFF_FFFF, In1Val,        1'b1, 0};
    vecs[7] = '{1, 1'b1, OUT1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
    vecs[8] = '{1, 1'b0, OUT1, 32'h0000_0000, 32'h0000_0000, 1'b0, 0};

    repeat (3) tick();
    chk_reset("init");
    chk("init_dut1_busy", bus1.busy, 0);
    chk("init_dut1_grant", bus1.grant, 0);
    rst = 1'b1;
    tick();

    // Ties: requester 0 first after reset; then with 0 served last, 1 first.
    tie_rd(0);
    do_single(0, 1'b0, OUT1, '0, g0_out1, 1'b0, 0);
    tie_rd(1);

    for (int i = 0; i < 9; i++) begin
      do_single(vecs[i].who, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].err,
                vecs[i].gwe);
    end

    // Fields latched at selection; dropping req in WAIT still completes.
    tick();
    drive(0, 1'b1, 1'b1, OUT2, 32'h1);
    c0 = cyc;
    sb.push_back('{0, 32'h1, 1'b0, c0 + 3});
    tick();
    bus0.m0_wd = 32'h2;
    tick();
    bus0.m0_req = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (ack_now[0] == 1'b1) got = 1;
    end
    drive(0, 1'b0, 1'b0, 2'b00, '0);
    chk("drop_ack_seen", got, 1);
    chk("latched_wd", g0_out2, 32'h1);

    // Reset during ISSUE of a write.
    chk("pre_rst_sb_empty", sb.size(), 0);
    tick();
    drive(0, 1'b1, 1'b1, OUT1, 32'h55AA_55AA);
    tick();
    chk("issue_g_we", bus0.g_we, 1);
    #1 rst = 1'b0;
    #1 chk_reset("midrst");
    drive(0, 1'b0, 1'b0, 2'b00, '0);
    tick();
    tick();
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack_now != 2'b00) acks++;
    end
    chk("rst_no_ack", acks, 0);
    chk("rst_no_write", g0_out1, 32'h0);
    do_single(0, 1'b1, OUT1, 32'h600D_F00D, 32'h600D_F00D, 1'b0, 1);

    // Fixed priority: continuous ties all go to requester 0.
    tick();
    bus1.m0_req = 1'b1; bus1.m0_a = OUT1;
    bus1.m1_req = 1'b1; bus1.m1_a = OUT2;
    n0a = 0;
    n1a = 0;
    g1c = 0;
    for (int i = 0; i < 20 && n0a < 3; i++) begin
      tick();
      if (bus1.m0_ack) n0a++;
      if (bus1.m1_ack) n1a++;
      if (bus1.grant == 2'b10) g1c++;
    end
    bus1.m0_req = 1'b0;
    bus1.m1_req = 1'b0;
    chk("fixed_m0_acks", n0a, 3);
    chk("fixed_m1_acks", n1a, 0);
    chk("fixed_m1_grant_cycles", g1c, 0);
    chk("fixed_m0_rd", bus1.m0_rd, 32'h1111_0000);

    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_arbiter.md
GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = requester 0 always wins.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports m0_req / m1_req, input, 1 each, transaction request; held high until ack.
REQ-005 SHALL have ports m0_we / m1_we, input, 1 each, write request qualifier.
REQ-006 SHALL have ports m0_a / m1_a, input, 2 each, GPIO register address: 00 = in1, 01 = in2, 10 = out1, 11 = out2.
REQ-007 SHALL have ports m0_wd / m1_wd, input, 32 each, write data.
REQ-008 SHALL have ports m0_ack / m1_ack, output, 1 each, one-cycle completion pulse.
REQ-009 SHALL have ports m0_err / m1_err, output, 1 each, valid with ack, flags an illegal write.
REQ-010 SHALL have ports m0_rd / m1_rd, output, 32 each, read data; valid with ack, held until that requester's next ack.
REQ-011 SHALL have port g_we, output, 1, write enable to the GPIO block.
REQ-012 SHALL have port g_a, output, 2, address to the GPIO block.
REQ-013 SHALL have port g_wd, output, 32, write data to the GPIO block.
REQ-014 SHALL have port g_rd, input, 32, read data from the GPIO block.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port grant, output, 2, one-hot owner of the current transaction; 00 when IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one cycle per state except IDLE.
REQ-018 In IDLE, any req high at a clock edge SHALL select a winner, latch its we/a/wd into internal registers, set grant, and enter ISSUE.
REQ-019 With both requests high and FIXED_PRIO=0, the winner SHALL be the requester not served last; after reset requester 0 has priority.
REQ-020 With FIXED_PRIO=1, requester 0 SHALL win every tie.
REQ-021 ISSUE SHALL drive g_a and g_wd from the latched values, and g_we = latched we AND a[1].
REQ-022 WAIT SHALL hold g_a and g_wd with g_we=0.
REQ-023 At the edge leaving WAIT, the winner's rd SHALL be loaded from g_rd; the other requester's rd is unchanged.
REQ-024 RESP SHALL assert the winner's ack for exactly one cycle.
REQ-025 Latency SHALL be: req sampled at edge N, ISSUE in cycle N+1, ack high in cycle N+3; maximum throughput one transaction per 4 cycles.
REQ-026 A write with a[1]=0 (input port) SHALL suppress g_we and assert err together with ack; rd SHALL still return g_rd.
REQ-027 Latched request fields SHALL be immune to changes on m*_we/a/wd after the winner is selected.
REQ-028 If the winner drops req mid-transaction, the transaction SHALL complete and ack SHALL still pulse.
REQ-029 A req still high in the IDLE cycle following RESP SHALL be treated as a new transaction and arbitrated normally.
REQ-030 g_we SHALL never be high outside ISSUE.
REQ-031 Round-robin state SHALL update only on entry to ISSUE.

Reset
REQ-032 On rst low, asynchronously: state=IDLE, g_we=0, g_a=00, g_wd=0, acks=0, errs=0, m0_rd=m1_rd=0, grant=00, busy=0, priority to requester 0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ack issued; g_we drops immediately.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (2-bit), the GPIO address constants (IN1, IN2, OUT1, OUT2) and the 32-bit data width.
REQ-035 The arbitration decision SHALL be a sub-module rr_arb2 (req[1:0], last, fixed -> gnt one-hot); all other logic stays in gpio_arbiter.

Verification
REQ-036 m0 write a=10, wd=0xDEADBEEF alone -> g_we high in exactly one cycle (N+1); m0_ack at N+3; GPIO out1 reads 0xDEADBEEF.
REQ-037 m0 and m1 both request reads at the same edge, FIXED_PRIO=0 -> m0 acked first, m1 acked 4 cycles later; repeated tie -> m1 first.
REQ-038 m1 write a=01, wd=0x12345678 -> g_we stays 0 throughout, m1_err=1 with m1_ack, m1_rd = current in2 value.
REQ-039 m0 changes wd from 0x1 to 0x2 during ISSUE -> GPIO receives 0x1; m0 drops req in WAIT -> m0_ack still pulses.
REQ-040 rst pulled low during ISSUE of a write -> g_we low asynchronously, no ack, all outputs at reset values, next transaction completes normally.
REQ-041 FIXED_PRIO=1, both requesters requesting continuously for 3 transactions -> m0 receives all 3 grants and m1 none.
